// File: rtl/pwm_prescaler_mc.sv
// pwm_prescaler_mc
//
// Multi-channel PWM prescaler. Each channel divides clk_psc_i by (shadow + 1).
// It emits a one-cycle ck_cnt_o enable per period, which paces a downstream
// PWM counter. The channels share no state.
//
// The preload is shadowed. A new psc_preload_i value takes effect only:
//   - at a wrap,
//   - on an update-generate pulse (ug_i), or
//   - while the channel is disabled (the shadow tracks the preload then).
// So a period that is already in progress always completes with its old
// ratio.
//
// Ports (channel c occupies bits [c*PSC_WIDTH +: PSC_WIDTH] of packed buses):
//   clk_psc_i      prescaler clock, rising edge
//   rst_i          synchronous active-high reset
//   cen_i          per-channel counter enable (level)
//   opm_i          per-channel one-pulse mode, sampled at the wrap edge
//   ug_i           per-channel update-generate pulse
//   psc_preload_i  per-channel preload values
//   ck_cnt_o       per-channel clock-enable pulse, one per division period
//   uev_o          per-channel update event (shadow reloaded)
//   psc_cnt_o      per-channel counter readback
//   done_o         per-channel one-pulse completion flag
module pwm_prescaler_mc #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned PSC_WIDTH = 16
) (
    input  logic                        clk_psc_i,
    input  logic                        rst_i,
    input  logic [NUM_CH-1:0]           cen_i,
    input  logic [NUM_CH-1:0]           opm_i,
    input  logic [NUM_CH-1:0]           ug_i,
    input  logic [NUM_CH*PSC_WIDTH-1:0] psc_preload_i,
    output logic [NUM_CH-1:0]           ck_cnt_o,
    output logic [NUM_CH-1:0]           uev_o,
    output logic [NUM_CH*PSC_WIDTH-1:0] psc_cnt_o,
    output logic [NUM_CH-1:0]           done_o
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [PSC_WIDTH-1:0] preload;
        logic [PSC_WIDTH-1:0] cnt_q, cnt_d;
        logic [PSC_WIDTH-1:0] shadow_q, shadow_d;
        logic                 done_q, done_d;
        logic                 ck_q, ck_d;
        logic                 uev_q, uev_d;

        assign preload = psc_preload_i[c*PSC_WIDTH +: PSC_WIDTH];

        always_comb begin
            cnt_d    = cnt_q;
            shadow_d = shadow_q;
            done_d   = done_q;
            ck_d     = 1'b0;
            uev_d    = 1'b0;
            if (ug_i[c]) begin
                // Software update wins over everything, including a wrap on
                // this same edge.
                cnt_d    = '0;
                shadow_d = preload;
                done_d   = 1'b0;
                uev_d    = 1'b1;
            end else if (!cen_i[c]) begin
                // The shadow follows the preload while the channel is
                // disabled, so the first period after enable already uses it.
                cnt_d    = '0;
                shadow_d = preload;
                done_d   = 1'b0;
            end else if (done_q) begin
                // One-pulse mode finished: the channel holds its state until
                // cen_i drops or ug_i is pulsed.
            end else if (cnt_q == shadow_q) begin
                cnt_d    = '0;
                shadow_d = preload;
                ck_d     = 1'b1;
                uev_d    = 1'b1;
                done_d   = opm_i[c];
            end else begin
                // cnt_q < shadow_q here, so the increment cannot overflow.
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk_psc_i) begin
            if (rst_i) begin
                cnt_q    <= '0;
                shadow_q <= '0;
                done_q   <= 1'b0;
                ck_q     <= 1'b0;
                uev_q    <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                shadow_q <= shadow_d;
                done_q   <= done_d;
                ck_q     <= ck_d;
                uev_q    <= uev_d;
            end
        end

        assign ck_cnt_o[c]                           = ck_q;
        assign uev_o[c]                              = uev_q;
        assign done_o[c]                             = done_q;
        assign psc_cnt_o[c*PSC_WIDTH +: PSC_WIDTH]   = cnt_q;
    end

endmodule

// File: tb/tb_pwm_prescaler_mc.sv
// Testbench for pwm_prescaler_mc.
//
// A reference model runs on every rising edge. It pushes the outputs it
// expects for that cycle into exp_q. Directed scenarios also push expected
// values, derived by hand, into dir_q. A single monitor samples the DUT
// outputs on the falling edge, pops both queues and compares.
//
// The bench uses a 4-bit counter width so that wrap at the all-ones preload
// can be reached in simulation.
module tb_pwm_prescaler_mc;

    localparam int unsigned NCH = 3;
    localparam int unsigned W   = 4;

    logic               clk;
    logic               rst;
    logic [NCH-1:0]     cen;
    logic [NCH-1:0]     opm;
    logic [NCH-1:0]     ug;
    logic [NCH*W-1:0]   pre_bus;
    logic [NCH-1:0]     ck_cnt;
    logic [NCH-1:0]     uev;
    logic [NCH*W-1:0]   psc_cnt;
    logic [NCH-1:0]     done;

    pwm_prescaler_mc #(
        .NUM_CH   (NCH),
        .PSC_WIDTH(W)
    ) u_dut (
        .clk_psc_i    (clk),
        .rst_i        (rst),
        .cen_i        (cen),
        .opm_i        (opm),
        .ug_i         (ug),
        .psc_preload_i(pre_bus),
        .ck_cnt_o     (ck_cnt),
        .uev_o        (uev),
        .psc_cnt_o    (psc_cnt),
        .done_o       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [NCH-1:0]   ck;
        logic [NCH-1:0]   uev;
        logic [NCH-1:0]   done;
        logic [NCH*W-1:0] cnt;
    } exp_t;

    typedef struct {
        int     ch;
        bit     ck;
        bit     uev;
        bit     done;
        int     cnt;
        string  nm;
    } dir_t;

    exp_t exp_q[$];
    dir_t dir_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model. Each channel is described by:
    //   ratio - the current division ratio
    //   pos   - the number of enabled edges elapsed in the current period
    //   fin   - whether one-pulse mode has completed
    int unsigned m_pos[NCH];
    int unsigned m_ratio[NCH];
    bit          m_fin[NCH];

    always @(posedge clk) begin
        exp_t e;
        e = '0;
        for (int c = 0; c < NCH; c++) begin
            int unsigned p;
            p = int'(pre_bus[c*W +: W]);
            if (rst) begin
                m_pos[c] = 0; m_ratio[c] = 1; m_fin[c] = 1'b0;
            end else if (ug[c]) begin
                m_pos[c] = 0; m_ratio[c] = p + 1; m_fin[c] = 1'b0;
                e.uev[c] = 1'b1;
            end else if (!cen[c]) begin
                m_pos[c] = 0; m_ratio[c] = p + 1; m_fin[c] = 1'b0;
            end else if (m_fin[c]) begin
                // Stopped after a one-pulse period.
            end else if (m_pos[c] + 1 == m_ratio[c]) begin
                m_pos[c] = 0; m_ratio[c] = p + 1;
                e.ck[c] = 1'b1; e.uev[c] = 1'b1;
                if (opm[c]) m_fin[c] = 1'b1;
            end else begin
                m_pos[c] = m_pos[c] + 1;
            end
            e.done[c]        = m_fin[c];
            e.cnt[c*W +: W]  = W'(m_pos[c]);
        end
        exp_q.push_back(e);
    end

    task automatic chk(input string nm, input int ch, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s ch%0d: got %0h, expected %0h at %0t", nm, ch, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            for (int c = 0; c < NCH; c++) begin
                chk("model_ck", c, 32'(ck_cnt[c]), 32'(e.ck[c]));
                chk("model_uev", c, 32'(uev[c]), 32'(e.uev[c]));
                chk("model_done", c, 32'(done[c]), 32'(e.done[c]));
                chk("model_cnt", c, 32'(psc_cnt[c*W +: W]), 32'(e.cnt[c*W +: W]));
            end
        end
        while (dir_q.size() != 0) begin
            dir_t d;
            d = dir_q.pop_front();
            chk({d.nm, "_ck"}, d.ch, 32'(ck_cnt[d.ch]), 32'(d.ck));
            chk({d.nm, "_uev"}, d.ch, 32'(uev[d.ch]), 32'(d.uev));
            chk({d.nm, "_done"}, d.ch, 32'(done[d.ch]), 32'(d.done));
            chk({d.nm, "_cnt"}, d.ch, 32'(psc_cnt[d.ch*W +: W]), d.cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ch(input string nm, input int ch, input bit ck, input bit ue,
                             input bit dn, input int cnt);
        dir_t d;
        d.nm = nm; d.ch = ch; d.ck = ck; d.uev = ue; d.done = dn; d.cnt = cnt;
        dir_q.push_back(d);
    endtask

    task automatic set_pre(input int ch, input int v);
        pre_bus[ch*W +: W] = W'(v);
    endtask

    initial begin
        rst = 1'b1; cen = '0; opm = '0; ug = '0; pre_bus = '0;
        set_pre(0, 3); set_pre(1, 0); set_pre(2, 15);
        tick(); tick();
        for (int c = 0; c < NCH; c++) expect_ch("reset", c, 0, 0, 0, 0);

        // Basic division: ch0 divides by 4, ch1 pulses every cycle.
        // One disabled edge lets the shadows pick up the preloads.
        rst = 1'b0;
        tick();
        cen = 3'b011;
        for (int i = 1; i <= 12; i++) begin
            tick();
            expect_ch("div4", 0, (i % 4) == 0, (i % 4) == 0, 0, i % 4);
            expect_ch("div1", 1, 1, 1, 0, 0);
        end

        // Shadowing: ch0 runs with P=5, and the preload is changed to 1
        // after two edges. The current period still ends at cnt 5.
        set_pre(0, 5); cen[0] = 1'b0;
        tick();
        cen[0] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            int ec;
            bit ek;
            if (i == 3) set_pre(0, 1);
            tick();
            ek = (i == 6) || (i == 8) || (i == 10);
            ec = (i <= 5) ? i : ((i == 7 || i == 9) ? 1 : 0);
            expect_ch("shadow", 0, ek, ek, 0, ec);
        end

        // One-pulse mode on ch2 with P=2.
        set_pre(2, 2); opm[2] = 1'b1;
        tick();
        cen[2] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            expect_ch("opm", 2, i == 3, i == 3, i >= 3, (i < 3) ? i : 0);
        end
        cen[2] = 1'b0;
        tick();
        expect_ch("opm_clear", 2, 0, 0, 0, 0);
        cen[2] = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            expect_ch("opm_restart", 2, i == 3, i == 3, i == 3, (i < 3) ? i : 0);
        end
        cen[2] = 1'b0; opm[2] = 1'b0;

        // ug_i on the wrap edge of ch0 with P=4.
        set_pre(0, 4); cen[0] = 1'b0;
        tick();
        cen[0] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            expect_ch("ug_pre", 0, 0, 0, 0, i);
        end
        ug[0] = 1'b1;
        tick();
        ug[0] = 1'b0;
        expect_ch("ug_wrap", 0, 0, 1, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            expect_ch("ug_after", 0, i == 5, i == 5, 0, i % 5);
        end

        // Reset mid-count on ch1 with P=9, then restart as from power-up.
        set_pre(1, 9); cen[1] = 1'b0;
        tick();
        cen[1] = 1'b1;
        for (int i = 1; i <= 7; i++) tick();
        expect_ch("pre_rst", 1, 0, 0, 0, 7);
        rst = 1'b1;
        tick();
        for (int c = 0; c < NCH; c++) expect_ch("mid_rst", c, 0, 0, 0, 0);
        rst = 1'b0; cen = '0;
        tick();
        cen[1] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            expect_ch("post_rst", 1, i == 10, i == 10, 0, i % 10);
        end

        // Randomized phase, checked against the model. Preloads are biased
        // towards 0, 1, 14 and the all-ones value 15.
        cen = '1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 399) == 0);
            for (int c = 0; c < NCH; c++) begin
                ug[c] = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 19) == 0) cen[c] = ~cen[c];
                if ($urandom_range(0, 63) == 0) opm[c] = ~opm[c];
                if ($urandom_range(0, 9) == 0) begin
                    case ($urandom_range(0, 7))
                        0: set_pre(c, 0);
                        1: set_pre(c, 1);
                        2: set_pre(c, 15);
                        3: set_pre(c, 14);
                        default: set_pre(c, int'($urandom_range(0, 15)));
                    endcase
                end
            end
            tick();
        end
        rst = 1'b0; ug = '0;
        tick(); tick();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
